// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file read arbiter.
//   ADDR_W        : default register select width
//   DATA_W        : default register data width
//   MAX_REQ       : largest supported requester count
//   REG_ZERO      : register number that always reads as zero
//   onehot_to_idx : index of the set bit in a one-hot vector (0 when empty)
package regfile_pkg;

  localparam int ADDR_W  = 5;
  localparam int DATA_W  = 32;
  localparam int MAX_REQ = 8;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  // OR-reduction of the indices of all set bits; exact for a one-hot input
  // and avoids a priority chain.
  function automatic logic [2:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = idx | 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/regfile_read_arbiter_rr.sv
// Combinational round-robin picker.
// Ports:
//   elig_i    : eligible requesters
//   ptr_i     : highest-priority index this cycle (0..NUM_REQ-1)
//   win_oh_o  : winner, one-hot (zero when nobody is eligible)
//   win_idx_o : winner index (0 when nobody is eligible)
//   any_o     : a winner exists
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] elig_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] win_oh_o,
  output logic [IDX_W-1:0]   win_idx_o,
  output logic               any_o
);

  import regfile_pkg::*;

  // One extra bit so ptr + offset can be wrapped without overflow.
  logic [IDX_W:0] pos;

  always_comb begin
    pos      = '0;
    win_oh_o = '0;
    any_o    = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = {1'b0, ptr_i} + (IDX_W+1)'(k);
      if (pos >= (IDX_W+1)'(NUM_REQ)) pos = pos - (IDX_W+1)'(NUM_REQ);
      if (!any_o && elig_i[pos[IDX_W-1:0]]) begin
        win_oh_o[pos[IDX_W-1:0]] = 1'b1;
        any_o                    = 1'b1;
      end
    end
  end

  assign win_idx_o = IDX_W'(onehot_to_idx(MAX_REQ'(win_oh_o)));

endmodule

// File: rtl/regfile_read_arbiter.sv
// Shares one register-file read port among NUM_REQ requesters.
// Stage A arbitrates round-robin and registers the grant and read select;
// stage B captures the read data (with register-0 zeroing and same-cycle
// write forwarding) and returns it to the granted requester.
// Ports:
//   clock, ctrl_reset   : clock, synchronous active-high reset
//   req, req_addr       : per-requester level request and register number
//   gnt                 : one-hot grant pulse
//   ctrl_readReg        : select to the register-file read port
//   data_readReg        : combinational read data from the register file
//   ctrl_writeEnable,
//   ctrl_writeReg,
//   data_writeReg       : snooped register-file write port
//   rsp_valid, rsp_data : one-hot response pulse and its data
module regfile_read_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = regfile_pkg::ADDR_W,
  parameter int DATA_W  = regfile_pkg::DATA_W
) (
  input  logic                      clock,
  input  logic                      ctrl_reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [ADDR_W-1:0]         ctrl_readReg,
  input  logic [DATA_W-1:0]         data_readReg,
  input  logic                      ctrl_writeEnable,
  input  logic [ADDR_W-1:0]         ctrl_writeReg,
  input  logic [DATA_W-1:0]         data_writeReg,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data
);

  import regfile_pkg::*;

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [ADDR_W-1:0]  readreg_q, readreg_d;
  logic               issue_valid_q, issue_valid_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;

  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] win_oh;
  logic [IDX_W-1:0]   win_idx;
  logic               win_any;

  logic [ADDR_W-1:0]  addr_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_addr
    assign addr_arr[i] = req_addr[i*ADDR_W +: ADDR_W];
  end

  // Last cycle's winner sits out one cycle, so a requester holding req
  // high is granted at most every other cycle.
  assign elig = req & ~gnt_q;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .elig_i    (elig),
    .ptr_i     (ptr_q),
    .win_oh_o  (win_oh),
    .win_idx_o (win_idx),
    .any_o     (win_any)
  );

  // Stage A: grant and read select. The select holds when idle so the
  // register-file port does not toggle needlessly.
  always_comb begin
    gnt_d         = '0;
    readreg_d     = readreg_q;
    issue_valid_d = 1'b0;
    ptr_d         = ptr_q;
    if (win_any) begin
      gnt_d         = win_oh;
      readreg_d     = addr_arr[win_idx];
      issue_valid_d = 1'b1;
      ptr_d         = (win_idx == IDX_W'(NUM_REQ-1)) ? '0 : win_idx + IDX_W'(1);
    end
  end

  // Stage B: capture. A write landing in the same cycle has not reached
  // the array yet, so its data is forwarded; register 0 is always zero.
  always_comb begin
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    if (issue_valid_q) begin
      rsp_valid_d = gnt_q;
      if (readreg_q == ADDR_W'(REG_ZERO)) begin
        rsp_data_d = '0;
      end else if (ctrl_writeEnable && (ctrl_writeReg == readreg_q)) begin
        rsp_data_d = data_writeReg;
      end else begin
        rsp_data_d = data_readReg;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      gnt_q         <= '0;
      readreg_q     <= '0;
      issue_valid_q <= 1'b0;
      ptr_q         <= '0;
      rsp_valid_q   <= '0;
      rsp_data_q    <= '0;
    end else begin
      gnt_q         <= gnt_d;
      readreg_q     <= readreg_d;
      issue_valid_q <= issue_valid_d;
      ptr_q         <= ptr_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
    end
  end

  assign gnt          = gnt_q;
  assign ctrl_readReg = readreg_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;

endmodule

// File: tb/tb_regfile_read_arbiter.sv
module tb_regfile_read_arbiter;

  localparam int NR = 4;
  localparam int AW = 5;
  localparam int DW = 32;

  logic              clock = 1'b0;
  logic              ctrl_reset;
  logic [NR-1:0]     req;
  logic [NR*AW-1:0]  req_addr;
  logic [NR-1:0]     gnt;
  logic [AW-1:0]     ctrl_readReg;
  logic [DW-1:0]     data_readReg;
  logic              ctrl_writeEnable;
  logic [AW-1:0]     ctrl_writeReg;
  logic [DW-1:0]     data_writeReg;
  logic [NR-1:0]     rsp_valid;
  logic [DW-1:0]     rsp_data;

  always #5 clock = ~clock;

  regfile_read_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clock            (clock),
    .ctrl_reset       (ctrl_reset),
    .req              (req),
    .req_addr         (req_addr),
    .gnt              (gnt),
    .ctrl_readReg     (ctrl_readReg),
    .data_readReg     (data_readReg),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg),
    .rsp_valid        (rsp_valid),
    .rsp_data         (rsp_data)
  );

  // Register-file model: combinational read, write applied at the edge.
  logic [DW-1:0] regs [32];
  logic          force_ones;
  assign data_readReg = force_ones ? '1 : regs[ctrl_readReg];

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  typedef struct {
    int          cyc;
    logic [3:0]  oh;
    logic [31:0] val;
  } exp_t;

  exp_t gq[$];
  exp_t rq[$];
  exp_t ge, re;

  task automatic push(input int c, input int idx, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    e.cyc = c;     e.oh = 4'(1 << idx); e.val = a;
    gq.push_back(e);
    e.cyc = c + 1; e.val = d;
    rq.push_back(e);
  endtask

  // Scoreboard: every grant / response pulse must match the next entry.
  always @(negedge clock) begin
    if (gnt != '0) begin
      if (gq.size() == 0) chk("gnt_unexpected", 32'(gnt), 32'd0);
      else begin
        ge = gq.pop_front();
        chk("gnt_cycle", 32'(cyc), 32'(ge.cyc));
        chk("gnt", 32'(gnt), 32'(ge.oh));
        chk("ctrl_readReg", 32'(ctrl_readReg), ge.val);
      end
    end
    if (rsp_valid != '0) begin
      if (rq.size() == 0) chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
      else begin
        re = rq.pop_front();
        chk("rsp_cycle", 32'(cyc), 32'(re.cyc));
        chk("rsp_valid", 32'(rsp_valid), 32'(re.oh));
        chk("rsp_data", rsp_data, re.val);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
    if (ctrl_writeEnable) regs[ctrl_writeReg] = data_writeReg;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_addr(input int i, input logic [AW-1:0] a);
    req_addr[i*AW +: AW] = a;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int t;

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'(i) * 32'h0101_0101 + 32'hA000_0000;
    force_ones       = 1'b0;
    ctrl_reset       = 1'b1;
    req              = '0;
    req_addr         = '0;
    ctrl_writeEnable = 1'b0;
    ctrl_writeReg    = '0;
    data_writeReg    = '0;

    // Reset state
    idle(2);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_readReg", 32'(ctrl_readReg), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    ctrl_reset = 1'b0;
    idle(2);

    // All four requesting, pointer 0: 0001,0010,0100,1000,0001
    for (int i = 0; i < NR; i++) set_addr(i, AW'(i + 1));
    req = 4'b1111;
    t = cyc;
    push(t + 1, 0, 1, regs[1]);
    push(t + 2, 1, 2, regs[2]);
    push(t + 3, 2, 3, regs[3]);
    push(t + 4, 3, 4, regs[4]);
    push(t + 5, 0, 1, regs[1]);
    idle(5);
    req = '0;
    idle(3);
    chk("readReg_hold", 32'(ctrl_readReg), 32'd1);

    // Single request: requester 0 reads register 5
    regs[5] = 32'hDEAD_BEEF;
    set_addr(0, 5);
    req = 4'b0001;
    t = cyc;
    push(t + 1, 0, 5, 32'hDEAD_BEEF);
    tick();
    req = '0;
    idle(3);
    chk("rsp_data_hold", rsp_data, 32'hDEAD_BEEF);

    // Register 0 reads as zero even if the array returns ones
    force_ones = 1'b1;
    set_addr(1, 0);
    req = 4'b0010;
    t = cyc;
    push(t + 1, 1, 0, 32'h0);
    tick();
    req = '0;
    idle(2);
    force_ones = 1'b0;
    idle(1);

    // Same-cycle write to the read register is forwarded
    regs[7] = 32'h11;
    set_addr(2, 7);
    req = 4'b0100;
    t = cyc;
    push(t + 1, 2, 7, 32'h22);
    tick();
    req = '0;
    ctrl_writeEnable = 1'b1; ctrl_writeReg = 7; data_writeReg = 32'h22;
    tick();
    ctrl_writeEnable = 1'b0;
    regs[7] = 32'h11;
    idle(2);

    // Same-cycle write to another register is not forwarded
    req = 4'b0100;
    t = cyc;
    push(t + 1, 2, 7, 32'h11);
    tick();
    req = '0;
    ctrl_writeEnable = 1'b1; ctrl_writeReg = 8; data_writeReg = 32'h22;
    tick();
    ctrl_writeEnable = 1'b0;
    idle(2);

    // Write one cycle before the read is already in the array
    req = 4'b0100;
    ctrl_writeEnable = 1'b1; ctrl_writeReg = 7; data_writeReg = 32'h33;
    t = cyc;
    push(t + 1, 2, 7, 32'h33);
    tick();
    ctrl_writeEnable = 1'b0;
    req = '0;
    idle(3);

    // Requester 2 holding req alone: granted every other cycle
    set_addr(2, 12);
    req = 4'b0100;
    t = cyc;
    push(t + 1, 2, 12, regs[12]);
    push(t + 3, 2, 12, regs[12]);
    push(t + 5, 2, 12, regs[12]);
    idle(5);
    req = '0;
    idle(3);

    // Reset in the cycle gnt=0010 discards the read and clears the pointer
    set_addr(1, 9);
    set_addr(3, 10);
    req = 4'b0010;
    t = cyc;
    ge.cyc = t + 1; ge.oh = 4'b0010; ge.val = 32'd9;
    gq.push_back(ge);
    tick();
    ctrl_reset = 1'b1;
    req = 4'b1010;
    tick();
    chk("midrst_gnt", 32'(gnt), 32'd0);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_rsp_data", rsp_data, 32'd0);
    chk("midrst_readReg", 32'(ctrl_readReg), 32'd0);
    ctrl_reset = 1'b0;
    t = cyc;
    push(t + 1, 1, 9, regs[9]);
    tick();
    req = '0;
    idle(5);

    chk("gnt_queue_left", 32'(gq.size()), 32'd0);
    chk("rsp_queue_left", 32'(rq.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
